// File: rtl/alu_seq_pipe_pkg.sv
// Shared types and operation encodings for the registered, handshaked ALU.
// Imported by the pipelined ALU top and its shift-add multiplier.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_SHR   = 3'b110;
  localparam logic [2:0] OP_PASS1 = 3'b111;

  localparam logic [2:0] LOP_AND   = 3'b000;
  localparam logic [2:0] LOP_OR    = 3'b001;
  localparam logic [2:0] LOP_XOR   = 3'b010;
  localparam logic [2:0] LOP_NOT   = 3'b011;
  localparam logic [2:0] LOP_NAND  = 3'b100;
  localparam logic [2:0] LOP_NOR   = 3'b101;
  localparam logic [2:0] LOP_XNOR  = 3'b110;
  localparam logic [2:0] LOP_PASS2 = 3'b111;

  typedef struct packed {
    logic c;
    logic z;
    logic o;
    logic s;
  } flags_t;

  function automatic logic is_mul_op(input logic mode, input logic [2:0] opsel);
    return (mode == MODE_ARITH) && (opsel == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_seq_pipe_mul_shift_add.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, DWIDTH steps.
// The final step's sum is presented combinationally alongside done so the caller can register it.
module mul_shift_add
  import alu_seq_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int CNTW   = $clog2(DWIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DWIDTH-1:0]     op1,
  input  logic [DWIDTH-1:0]     op2,
  output logic                  done,
  output logic [2*DWIDTH-1:0]   product
);

  logic                  run_q;
  logic [CNTW-1:0]       cnt_q;
  logic [2*DWIDTH-1:0]   mcand_q;
  logic [DWIDTH-1:0]     mplr_q;
  logic [2*DWIDTH-1:0]   acc_q;
  logic [2*DWIDTH-1:0]   acc_d;

  always_comb begin
    acc_d = acc_q;
    if (mplr_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  // Step DWIDTH is the one in flight when cnt_q reaches DWIDTH-1.
  assign done    = run_q && (cnt_q == CNTW'(DWIDTH - 1));
  assign product = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
    end else if (start) begin
      run_q   <= 1'b1;
      cnt_q   <= '0;
      mcand_q <= {{DWIDTH{1'b0}}, op1};
      mplr_q  <= op2;
      acc_q   <= '0;
    end else if (run_q) begin
      acc_q   <= acc_d;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      cnt_q   <= cnt_q + 1'b1;
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq_pipe.sv
// Registered ALU with valid/ready handshakes on both sides; single-cycle ops land in the
// output register at accept, multiplies iterate in mul_shift_add first.
module alu_seq_pipe
  import alu_seq_pkg::*;
#(
  parameter  int DWIDTH = 32,
  localparam int CNTW   = $clog2(DWIDTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] op1,
  input  logic [DWIDTH-1:0] op2,
  input  logic [2:0]        opsel,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] result,
  output logic              c_flag,
  output logic              z_flag,
  output logic              o_flag,
  output logic              s_flag
);

  localparam int MSB = DWIDTH - 1;

  state_t state_q, state_d;
  logic [DWIDTH-1:0] result_q;
  flags_t            flags_q;

  logic accept;
  logic load_alu;
  logic load_mul;
  logic mul_start;
  logic mul_done;
  logic [2*DWIDTH-1:0] mul_product;

  logic [DWIDTH-1:0] add_b;
  logic              add_cin;
  logic              use_adder;
  logic [DWIDTH:0]   alu_sum;
  logic [DWIDTH-1:0] alu_res;
  logic              alu_c;
  logic              alu_o;
  flags_t            alu_flags;
  flags_t            mul_flags;

  always_comb begin
    add_b     = '0;
    add_cin   = 1'b0;
    use_adder = 1'b0;
    alu_res   = op1;
    alu_c     = 1'b0;
    alu_o     = 1'b0;
    alu_sum   = '0;
    if (mode == MODE_ARITH) begin
      case (opsel)
        OP_ADD: begin add_b = op2;  use_adder = 1'b1; end
        OP_SUB: begin add_b = ~op2; add_cin = 1'b1; use_adder = 1'b1; end
        OP_INC: begin add_b = '0;   add_cin = 1'b1; use_adder = 1'b1; end
        OP_DEC: begin add_b = '1;   use_adder = 1'b1; end
        OP_SHL: begin alu_res = {op1[MSB-1:0], 1'b0}; alu_c = op1[MSB]; end
        OP_SHR: begin alu_res = {1'b0, op1[MSB:1]};   alu_c = op1[0]; end
        default: alu_res = op1;
      endcase
      // Overflow when both addends share a sign that the sum does not.
      alu_sum = {1'b0, op1} + {1'b0, add_b} + {{DWIDTH{1'b0}}, add_cin};
      if (use_adder) begin
        alu_res = alu_sum[MSB:0];
        alu_c   = alu_sum[DWIDTH];
        alu_o   = (op1[MSB] == add_b[MSB]) && (alu_sum[MSB] != op1[MSB]);
      end
    end else begin
      case (opsel)
        LOP_AND:  alu_res = op1 & op2;
        LOP_OR:   alu_res = op1 | op2;
        LOP_XOR:  alu_res = op1 ^ op2;
        LOP_NOT:  alu_res = ~op1;
        LOP_NAND: alu_res = ~(op1 & op2);
        LOP_NOR:  alu_res = ~(op1 | op2);
        LOP_XNOR: alu_res = ~(op1 ^ op2);
        default:  alu_res = op2;
      endcase
    end
  end

  assign alu_flags.c = alu_c;
  assign alu_flags.z = (alu_res == '0);
  assign alu_flags.o = alu_o;
  assign alu_flags.s = alu_res[MSB];

  assign mul_flags.c = |mul_product[2*DWIDTH-1:DWIDTH];
  assign mul_flags.z = (mul_product[MSB:0] == '0);
  assign mul_flags.o = |mul_product[2*DWIDTH-1:DWIDTH];
  assign mul_flags.s = mul_product[MSB];

  mul_shift_add #(
    .DWIDTH (DWIDTH),
    .CNTW   (CNTW)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .op1     (op1),
    .op2     (op2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d   = state_q;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    mul_start = 1'b0;
    in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    accept    = in_valid && in_ready;
    case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          if (is_mul_op(mode, opsel)) begin
            mul_start = 1'b1;
            state_d   = BUSY;
          end else begin
            load_alu = 1'b1;
            state_d  = HOLD;
          end
        end else if ((state_q == HOLD) && out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (mul_done) begin
          load_mul = 1'b1;
          state_d  = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_alu) begin
        result_q <= alu_res;
        flags_q  <= alu_flags;
      end else if (load_mul) begin
        result_q <= mul_product[MSB:0];
        flags_q  <= mul_flags;
      end
    end
  end

  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign c_flag    = flags_q.c;
  assign z_flag    = flags_q.z;
  assign o_flag    = flags_q.o;
  assign s_flag    = flags_q.s;

endmodule

// File: tb/tb_alu_seq_pipe.sv
// Self-checking bench for alu_seq_pipe: directed corner cases, handshake stalls, reset abort
// and random operations compared against an arithmetic reference model.
module tb_alu_seq_pipe;

  localparam int DW = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, mode;
  logic c_flag, z_flag, o_flag, s_flag;
  logic [DW-1:0] op1, op2, result;
  logic [2:0] opsel;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct packed {
    logic [31:0] r;
    logic c;
    logic z;
    logic o;
    logic s;
  } exp_t;

  always #5 clk = ~clk;

  alu_seq_pipe #(.DWIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .opsel     (opsel),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c_flag    (c_flag),
    .z_flag    (z_flag),
    .o_flag    (o_flag),
    .s_flag    (s_flag)
  );

  function automatic exp_t ref_alu(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] sel, input logic md);
    exp_t e;
    longint sa, sb, sv;
    logic [63:0] u;
    logic arith;
    e = '0; sa = $signed(a); sb = $signed(b); sv = 0; u = '0; arith = 1'b0;
    if (!md) begin
      case (sel)
        3'd0: begin u = {32'b0, a} + {32'b0, b}; e.r = u[31:0]; e.c = u[32]; sv = sa + sb; arith = 1'b1; end
        3'd1: begin e.r = a - b; e.c = (a >= b); sv = sa - sb; arith = 1'b1; end
        3'd2: begin e.r = a + 32'd1; e.c = (a == 32'hFFFF_FFFF); sv = sa + 1; arith = 1'b1; end
        3'd3: begin e.r = a - 32'd1; e.c = (a != 32'd0); sv = sa - 1; arith = 1'b1; end
        3'd4: begin u = {32'b0, a} * {32'b0, b}; e.r = u[31:0]; e.c = (u[63:32] != 0); e.o = e.c; end
        3'd5: begin e.r = a << 1; e.c = a[31]; end
        3'd6: begin e.r = a >> 1; e.c = a[0]; end
        default: e.r = a;
      endcase
    end else begin
      case (sel)
        3'd0: e.r = a & b;
        3'd1: e.r = a | b;
        3'd2: e.r = a ^ b;
        3'd3: e.r = ~a;
        3'd4: e.r = ~(a & b);
        3'd5: e.r = ~(a | b);
        3'd6: e.r = ~(a ^ b);
        default: e.r = b;
      endcase
    end
    if (arith) e.o = (sv > SMAX) || (sv < SMIN);
    e.z = (e.r == 32'd0);
    e.s = e.r[31];
    return e;
  endfunction

  // Presents one request, waits for its result; leaves out_valid sampled high (out_ready=0).
  task automatic send_and_wait(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                               input logic md, output int lat, output bit ready_in_busy);
    int w;
    op1 = a; op2 = b; opsel = sel; mode = md; in_valid = 1'b1; out_ready = 1'b0;
    ready_in_busy = 1'b0; w = 0;
    #1;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid = 1'b0; op1 = $urandom; op2 = $urandom; opsel = 3'($urandom); mode = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_in_busy = 1'b1;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic exp_t observed();
    exp_t g;
    g = {result, c_flag, z_flag, o_flag, s_flag};
    return g;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op1 = '0; op2 = '0; opsel = '0; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (result !== '0) $display("FAIL reset_result: got %h want 0", result); else pass_cnt++;
    chk_cnt++; if ({c_flag, z_flag, o_flag, s_flag} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {c_flag, z_flag, o_flag, s_flag}); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_add_overflow();
    int lat; bit rb; exp_t e, snap;
    e = ref_alu(32'h7FFF_FFFF, 32'h0000_0001, 3'd0, 1'b0);
    send_and_wait(32'h7FFF_FFFF, 32'h0000_0001, 3'd0, 1'b0, lat, rb);
    $display("ADD 7fffffff+1 -> %h czos=%b%b%b%b lat=%0d", result, c_flag, z_flag, o_flag, s_flag, lat);
    chk_cnt++; if (lat !== 1) $display("FAIL add_latency: got %0d want 1", lat); else pass_cnt++;
    chk_cnt++; if (observed() !== e) $display("FAIL add_result: got %h want %h", observed(), e); else pass_cnt++;
    snap = e;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_cnt++; if (out_valid !== 1'b1 || observed() !== snap)
        $display("FAIL add_stall_stable: got v=%b %h want v=1 %h", out_valid, observed(), snap); else pass_cnt++;
    end
    consume();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL add_consumed: got out_valid=%b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_sub();
    int lat; bit rb; exp_t e;
    e = ref_alu(32'h5, 32'h5, 3'd1, 1'b0);
    send_and_wait(32'h5, 32'h5, 3'd1, 1'b0, lat, rb);
    $display("SUB 5-5 -> %h czos=%b%b%b%b", result, c_flag, z_flag, o_flag, s_flag);
    chk_cnt++; if (observed() !== e) $display("FAIL sub_equal: got %h want %h", observed(), e); else pass_cnt++;
    consume();
    e = ref_alu(32'h0, 32'h1, 3'd1, 1'b0);
    send_and_wait(32'h0, 32'h1, 3'd1, 1'b0, lat, rb);
    $display("SUB 0-1 -> %h czos=%b%b%b%b", result, c_flag, z_flag, o_flag, s_flag);
    chk_cnt++; if (observed() !== e) $display("FAIL sub_borrow: got %h want %h", observed(), e); else pass_cnt++;
    consume();
  endtask

  task automatic test_mul();
    int lat; bit rb; exp_t e;
    e = ref_alu(32'h0001_0000, 32'h0001_0000, 3'd4, 1'b0);
    send_and_wait(32'h0001_0000, 32'h0001_0000, 3'd4, 1'b0, lat, rb);
    $display("MUL 10000*10000 -> %h czos=%b%b%b%b lat=%0d", result, c_flag, z_flag, o_flag, s_flag, lat);
    chk_cnt++; if (lat !== DW + 1) $display("FAIL mul_latency: got %0d want %0d", lat, DW + 1); else pass_cnt++;
    chk_cnt++; if (rb !== 1'b0) $display("FAIL mul_in_ready_busy: got %b want 0", rb); else pass_cnt++;
    chk_cnt++; if (observed() !== e) $display("FAIL mul_result: got %h want %h", observed(), e); else pass_cnt++;
    consume();
  endtask

  task automatic test_back_to_back();
    localparam int N = 9;
    logic [31:0] a_t [N];
    logic [31:0] b_t [N];
    exp_t q[$];
    exp_t snap;
    int issued, consumed, cyc;
    bit exp_valid, exp_in_ready, in_xfer, stalled;
    for (int i = 0; i < N; i++) begin a_t[i] = $urandom; b_t[i] = $urandom; end
    issued = 0; consumed = 0; cyc = 0; exp_valid = 1'b0; snap = '0;
    while (consumed < N && cyc < 200) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (issued < N);
      if (issued < N) begin
        op1 = a_t[issued]; op2 = b_t[issued]; opsel = 3'(issued % 3); mode = 1'b1;
      end
      #1;
      exp_in_ready = !exp_valid || out_ready;
      chk_cnt++; if (in_ready !== exp_in_ready)
        $display("FAIL b2b_in_ready cyc%0d: got %b want %b", cyc, in_ready, exp_in_ready); else pass_cnt++;
      if (exp_valid && out_ready && q.size() > 0) begin
        $display("B2B take #%0d -> %h", consumed, result);
        chk_cnt++; if (observed() !== q[0])
          $display("FAIL b2b_result #%0d: got %h want %h", consumed, observed(), q[0]); else pass_cnt++;
        void'(q.pop_front());
        consumed++;
      end
      in_xfer = in_valid && exp_in_ready;
      if (in_xfer) begin
        q.push_back(ref_alu(a_t[issued], b_t[issued], 3'(issued % 3), 1'b1));
        issued++;
      end
      stalled = exp_valid && !out_ready;
      snap = observed();
      exp_valid = in_xfer || stalled;
      @(posedge clk); #1; cyc++;
      chk_cnt++; if (out_valid !== exp_valid)
        $display("FAIL b2b_out_valid cyc%0d: got %b want %b", cyc, out_valid, exp_valid); else pass_cnt++;
      if (stalled) begin
        chk_cnt++; if (observed() !== snap)
          $display("FAIL b2b_stall_stable cyc%0d: got %h want %h", cyc, observed(), snap); else pass_cnt++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk_cnt++; if (consumed !== N || q.size() !== 0)
      $display("FAIL b2b_count: got %0d consumed %0d left want %0d 0", consumed, q.size(), N); else pass_cnt++;
    if (out_valid) consume();
  endtask

  task automatic test_reset_mid_mul();
    int lat; bit rb, seen; exp_t e;
    op1 = $urandom; op2 = $urandom; opsel = 3'd4; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rst_mid_mul_idle: got v=%b r=%b want v=0 r=1", out_valid, in_ready); else pass_cnt++;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk_cnt++; if (seen !== 1'b0) $display("FAIL rst_mid_mul_no_output: got %b want 0", seen); else pass_cnt++;
    out_ready = 1'b0;
    e = ref_alu(32'h1234_5678, 32'h0FED_CBA9, 3'd0, 1'b0);
    send_and_wait(32'h1234_5678, 32'h0FED_CBA9, 3'd0, 1'b0, lat, rb);
    $display("ADD after abort -> %h", result);
    chk_cnt++; if (lat !== 1 || observed() !== e)
      $display("FAIL rst_mid_mul_next_add: got lat=%0d %h want lat=1 %h", lat, observed(), e); else pass_cnt++;
    consume();
  endtask

  task automatic test_random();
    logic [31:0] corners [5];
    logic [31:0] a, b;
    logic [2:0] sel;
    logic md;
    int lat, want_lat; bit rb; exp_t e;
    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 32; i++) begin
      a = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      sel = 3'($urandom); md = 1'($urandom);
      if (i < 16) begin md = 1'b0; sel = 3'(i % 8); end
      e = ref_alu(a, b, sel, md);
      want_lat = (!md && sel == 3'd4) ? DW + 1 : 1;
      send_and_wait(a, b, sel, md, lat, rb);
      $display("RND md=%0d sel=%0d a=%h b=%h -> %h czos=%b%b%b%b", md, sel, a, b, result,
               c_flag, z_flag, o_flag, s_flag);
      chk_cnt++; if (lat !== want_lat) $display("FAIL rnd_latency #%0d: got %0d want %0d", i, lat, want_lat); else pass_cnt++;
      chk_cnt++; if (observed() !== e) $display("FAIL rnd_result #%0d: got %h want %h", i, observed(), e); else pass_cnt++;
      consume();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_overflow();
    test_sub();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
